// File: rtl/reflet_bus_pkg.sv
// Shared definitions for the Reflet two-master bus arbiter: FSM state encoding
// and the owner status codes shown on the debug port.
package reflet_bus_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2,
      TURN = 2'd3
   } arb_state_t;

   localparam logic [1:0] OWNER_NONE = 2'b00;
   localparam logic [1:0] OWNER_M0   = 2'b01;
   localparam logic [1:0] OWNER_M1   = 2'b10;

endpackage

// File: rtl/reflet_bus_arbiter_if.sv
// One Reflet master link: the master drives request/address/data/strobe and
// the arbiter answers with the enable that stalls or runs that master.
interface reflet_bus_arbiter_if #(
   parameter int wordsize = 16
);
   logic                req;
   logic [wordsize-1:0] addr;
   logic [wordsize-1:0] data_out;
   logic                write_en;
   logic                enable;

   modport master (output req, addr, data_out, write_en, input enable);
   modport slave  (input req, addr, data_out, write_en, output enable);
endinterface

// File: rtl/reflet_bus_arbiter.sv
// Round-robin arbiter sharing one synchronous memory port between two Reflet
// masters, with bounded bursts and a one-cycle turnaround between owners.
module reflet_bus_arbiter
   import reflet_bus_pkg::*;
#(
   parameter int wordsize  = 16,
   parameter int max_burst = 8
) (
   input  logic                clk,
   input  logic                reset,
   reflet_bus_arbiter_if.slave m0,
   reflet_bus_arbiter_if.slave m1,
   output logic [wordsize-1:0] data_out,
   output logic [wordsize-1:0] mem_addr,
   output logic [wordsize-1:0] mem_data_out,
   output logic                mem_write_en,
   input  logic [wordsize-1:0] mem_data_in,
   output logic [1:0]          owner
);

   localparam int              CW   = $clog2(max_burst) + 1;
   localparam logic [CW-1:0]   LAST = CW'(max_burst - 1);

   arb_state_t          state, next_state;
   logic [CW-1:0]       counter, next_counter;
   logic                rr;
   logic [wordsize-1:0] hold_addr;

   // rr remembers the last owner (0 = m0, 1 = m1); in TURN it is the previous
   // owner, so the waiting master is ~rr. Counter restarts on every new grant.
   always_comb begin
      next_state   = state;
      next_counter = '0;
      case (state)
         IDLE: begin
            if (m0.req && m1.req) next_state = rr ? OWN0 : OWN1;
            else if (m0.req)      next_state = OWN0;
            else if (m1.req)      next_state = OWN1;
         end
         OWN0: begin
            if (!m0.req)                         next_state = m1.req ? TURN : IDLE;
            else if (m1.req && counter == LAST)  next_state = TURN;
            else begin
               next_state   = OWN0;
               next_counter = (counter == LAST) ? counter : counter + 1'b1;
            end
         end
         OWN1: begin
            if (!m1.req)                         next_state = m0.req ? TURN : IDLE;
            else if (m0.req && counter == LAST)  next_state = TURN;
            else begin
               next_state   = OWN1;
               next_counter = (counter == LAST) ? counter : counter + 1'b1;
            end
         end
         TURN: begin
            if (rr ? m0.req : m1.req)      next_state = rr ? OWN0 : OWN1;
            else if (rr ? m1.req : m0.req) next_state = rr ? OWN1 : OWN0;
            else                           next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // hold_addr keeps the last owner's address so TURN/IDLE present a stable
   // address rather than whatever a stalled master happens to drive.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         counter   <= '0;
         rr        <= 1'b1;
         hold_addr <= '0;
      end else begin
         state   <= next_state;
         counter <= next_counter;
         if (next_state == OWN0)      rr <= 1'b0;
         else if (next_state == OWN1) rr <= 1'b1;
         if (state == OWN0)      hold_addr <= m0.addr;
         else if (state == OWN1) hold_addr <= m1.addr;
      end
   end

   // Everything below depends only on registered state, so a request can never
   // reach an enable combinationally and writes are gated to owned cycles.
   always_comb begin
      m0.enable    = 1'b0;
      m1.enable    = 1'b0;
      owner        = OWNER_NONE;
      mem_addr     = hold_addr;
      mem_data_out = '0;
      mem_write_en = 1'b0;
      case (state)
         OWN0: begin
            m0.enable    = 1'b1;
            owner        = OWNER_M0;
            mem_addr     = m0.addr;
            mem_data_out = m0.data_out;
            mem_write_en = m0.write_en;
         end
         OWN1: begin
            m1.enable    = 1'b1;
            owner        = OWNER_M1;
            mem_addr     = m1.addr;
            mem_data_out = m1.data_out;
            mem_write_en = m1.write_en;
         end
         default: ;
      endcase
   end

   assign data_out = mem_data_in;

endmodule

// File: tb/tb_reflet_bus_arbiter.sv
// Directed bench for reflet_bus_arbiter with a small synchronous RAM on the
// memory port; expected values are hand-derived cycle by cycle.
module tb_reflet_bus_arbiter;

   logic        clk;
   logic        reset;
   logic [15:0] data_out;
   logic [15:0] mem_addr;
   logic [15:0] mem_data_out;
   logic        mem_write_en;
   logic [15:0] mem_data_in;
   logic [1:0]  owner;
   logic [15:0] ram [0:255];

   int checks   = 0;
   int failures = 0;

   reflet_bus_arbiter_if #(.wordsize(16)) m0_bus ();
   reflet_bus_arbiter_if #(.wordsize(16)) m1_bus ();

   reflet_bus_arbiter #(.wordsize(16), .max_burst(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .m0           (m0_bus),
      .m1           (m1_bus),
      .data_out     (data_out),
      .mem_addr     (mem_addr),
      .mem_data_out (mem_data_out),
      .mem_write_en (mem_write_en),
      .mem_data_in  (mem_data_in),
      .owner        (owner)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Synchronous RAM: read data appears one cycle after the address.
   always @(posedge clk) begin
      if (mem_write_en) ram[mem_addr[7:0]] <= mem_data_out;
      mem_data_in <= ram[mem_addr[7:0]];
   end

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // No memory write may ever be issued while nobody owns the bus.
   always @(negedge clk) begin
      if (owner == 2'b00) check_output("no_unowned_write", 32'(mem_write_en), 32'd0);
   end

   initial begin
      for (int i = 0; i < 256; i++) ram[i] = 16'h0000;
      mem_data_in      = 16'h0000;
      reset            = 1'b1;
      m0_bus.req       = 1'b1;
      m0_bus.addr      = 16'h0100;
      m0_bus.data_out  = 16'h0000;
      m0_bus.write_en  = 1'b0;
      m1_bus.req       = 1'b0;
      m1_bus.addr      = 16'h0000;
      m1_bus.data_out  = 16'h0000;
      m1_bus.write_en  = 1'b0;

      // Reset state with a request already pending.
      #12;
      check_output("rst_owner",  32'(owner), 32'd0);
      check_output("rst_m0_en",  32'(m0_bus.enable), 32'd0);
      check_output("rst_m1_en",  32'(m1_bus.enable), 32'd0);
      check_output("rst_we",     32'(mem_write_en), 32'd0);
      check_output("rst_addr",   32'(mem_addr), 32'd0);
      reset = 1'b0;

      // Lone m0 request: granted on the first edge, held for 50 cycles.
      tick();
      check_output("solo_owner", 32'(owner), 32'd1);
      check_output("solo_m0_en", 32'(m0_bus.enable), 32'd1);
      for (int i = 0; i < 50; i++) begin
         m0_bus.addr = 16'h0100 + 16'(i);
         #1;
         check_output("solo_addr",  32'(mem_addr), 32'h0100 + 32'(i));
         check_output("solo_own",   32'(owner), 32'd1);
         check_output("solo_m1_en", 32'(m1_bus.enable), 32'd0);
         tick();
      end

      // m1 arrives after the counter saturated: expiry is immediate.
      m1_bus.req = 1'b1;
      #1;
      check_output("late_no_comb", 32'(m1_bus.enable), 32'd0);
      tick();
      check_output("late_turn_owner", 32'(owner), 32'd0);
      check_output("late_turn_m0_en", 32'(m0_bus.enable), 32'd0);
      m0_bus.addr = 16'h0555;
      #1;
      check_output("late_turn_hold", 32'(mem_addr), 32'h0131);
      tick();
      check_output("late_m1_owner", 32'(owner), 32'd2);
      m1_bus.addr = 16'h0200;
      #1;
      check_output("late_m1_addr", 32'(mem_addr), 32'h0200);

      // Both drop: back to IDLE, strobes from masters are ignored there.
      m0_bus.req = 1'b0;
      m1_bus.req = 1'b0;
      tick();
      m0_bus.write_en = 1'b1;
      m1_bus.write_en = 1'b1;
      #1;
      check_output("idle_owner", 32'(owner), 32'd0);
      check_output("idle_we",    32'(mem_write_en), 32'd0);
      m1_bus.write_en = 1'b0;

      // Reset mid-burst at counter 3; rr must come back pointing to m0.
      m0_bus.req      = 1'b1;
      m1_bus.req      = 1'b1;
      m0_bus.addr     = 16'h00F0;
      m0_bus.data_out = 16'h1234;
      tick();
      check_output("pre_owner", 32'(owner), 32'd1);
      repeat (3) tick();
      check_output("pre_we", 32'(mem_write_en), 32'd1);
      #2 reset = 1'b1;
      #1;
      check_output("mid_rst_owner", 32'(owner), 32'd0);
      check_output("mid_rst_m0_en", 32'(m0_bus.enable), 32'd0);
      check_output("mid_rst_m1_en", 32'(m1_bus.enable), 32'd0);
      check_output("mid_rst_we",    32'(mem_write_en), 32'd0);
      check_output("mid_rst_addr",  32'(mem_addr), 32'd0);
      m0_bus.write_en = 1'b0;
      #2 reset = 1'b0;
      tick();
      check_output("tie_after_rst", 32'(owner), 32'd1);

      // Contention: m0 burst of 8, write BEEF on its last cycle, m1 reads it.
      repeat (6) begin
         tick();
         check_output("burst0_owner", 32'(owner), 32'd1);
         check_output("burst0_m1_en", 32'(m1_bus.enable), 32'd0);
      end
      tick();
      m0_bus.addr     = 16'h0010;
      m0_bus.data_out = 16'hBEEF;
      m0_bus.write_en = 1'b1;
      #1;
      check_output("wr_owner", 32'(owner), 32'd1);
      check_output("wr_we",    32'(mem_write_en), 32'd1);
      check_output("wr_addr",  32'(mem_addr), 32'h0010);
      check_output("wr_data",  32'(mem_data_out), 32'hBEEF);
      tick();
      check_output("turn_owner", 32'(owner), 32'd0);
      check_output("turn_we",    32'(mem_write_en), 32'd0);
      check_output("turn_m0_en", 32'(m0_bus.enable), 32'd0);
      check_output("turn_m1_en", 32'(m1_bus.enable), 32'd0);
      m0_bus.write_en = 1'b0;
      m1_bus.addr     = 16'h0010;
      tick();
      check_output("m1_owner", 32'(owner), 32'd2);
      check_output("m1_addr",  32'(mem_addr), 32'h0010);
      tick();
      check_output("m1_read", 32'(data_out), 32'hBEEF);
      repeat (6) begin
         tick();
         check_output("burst1_owner", 32'(owner), 32'd2);
      end
      tick();
      check_output("turn2_owner", 32'(owner), 32'd0);
      tick();
      check_output("rr_back_m0", 32'(owner), 32'd1);

      // m1 drops in its 3rd cycle while m0 waits.
      repeat (7) tick();
      tick();
      check_output("turn3_owner", 32'(owner), 32'd0);
      tick();
      tick();
      tick();
      m1_bus.req = 1'b0;
      #1;
      check_output("drop_no_comb", 32'(m1_bus.enable), 32'd1);
      tick();
      check_output("drop_turn", 32'(owner), 32'd0);
      check_output("drop_turn_m0_en", 32'(m0_bus.enable), 32'd0);
      tick();
      check_output("drop_m0_en", 32'(m0_bus.enable), 32'd1);

      // A request withdrawn during TURN is not granted.
      m0_bus.req = 1'b0;
      m1_bus.req = 1'b1;
      tick();
      check_output("wd_turn", 32'(owner), 32'd0);
      m1_bus.req = 1'b0;
      tick();
      check_output("wd_idle_owner", 32'(owner), 32'd0);
      check_output("wd_idle_m1_en", 32'(m1_bus.enable), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
